mem_read_a: RTL and testbench

Read-side sequencer for the banked A-matrix buffer. It streams the stored A tiles out of the N1 row-banks to the N1 rows of the systolic array. Each bank is read with a one-cycle-per-lane skew, so lane b lags lane 0 by b cycles, which is the diagonal wavefront the array needs. It consumes the same layout the A write path produces: bank b, phase p holds matrix row p·N1+b at addresses p·M2 … p·M2+M2−1. Each phase can be replayed `rep` times to reuse A against several B tiles.

---
 rtl/mm_pkg.sv | 15 +
 rtl/skew_delay.sv | 25 ++
 rtl/mem_read_a.sv | 167 ++++++++++++++++
 tb/tb_mem_read_a.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Types and helpers shared by the A-matrix buffer read and write paths.
package mm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   // LSB position of a lane inside a flat {lane N-1, ..., lane 0} address bus
   function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
      return lane * width;
   endfunction

endpackage

// File: rtl/skew_delay.sv
// DEPTH-stage WIDTH-bit shift register with synchronous clear; DEPTH must be at least 1.
module skew_delay #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/mem_read_a.sv
// Read sequencer for the banked A buffer: walks phase/replay/column counters and
// fans the lane-0 request out to N1 banks with a one-cycle-per-lane skew.
module mem_read_a
   import mm_pkg::*;
#(
   parameter int unsigned N1           = 4,
   parameter int unsigned MATRIXSIZE_W = 16,
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned RD_LAT       = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [MATRIXSIZE_W-1:0]  M2,
   input  logic [MATRIXSIZE_W-1:0]  M1dN1,
   input  logic [MATRIXSIZE_W-1:0]  rep,
   output logic [N1-1:0]            rd_en_A,
   output logic [N1*ADDR_W-1:0]     rd_addr_A,
   output logic [N1-1:0]            lane_valid,
   output logic [N1-1:0]            lane_last,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned DRAIN_LEN = N1 - 1 + RD_LAT;
   localparam int unsigned DCNT_W    = $clog2(DRAIN_LEN + 1);
   localparam logic [MATRIXSIZE_W-1:0] ONE = MATRIXSIZE_W'(1);

   state_t                  state;
   logic [MATRIXSIZE_W-1:0] m2_q, m1_q, rep_q;
   logic [MATRIXSIZE_W-1:0] k, r, p;
   logic [ADDR_W-1:0]       offset;
   logic [DCNT_W-1:0]       dcnt;

   // Lane-0 request registers; every other lane is a delayed copy of these
   logic                    en0, last0;
   logic [ADDR_W-1:0]       addr0;

   logic                    k_end, r_end, p_end, final_elem, p_adv;
   logic [MATRIXSIZE_W-1:0] k_nxt, r_nxt;
   logic [ADDR_W-1:0]       offset_nxt;

   assign k_end      = (k == m2_q - ONE);
   assign r_end      = (r == rep_q - ONE);
   assign p_end      = (p == m1_q - ONE);
   assign final_elem = k_end && r_end && p_end;
   assign p_adv      = k_end && r_end;
   assign k_nxt      = k_end ? '0 : k + ONE;
   assign r_nxt      = k_end ? (r_end ? '0 : r + ONE) : r;
   // Replays re-read the same rows, so the offset only moves on a phase change
   assign offset_nxt = p_adv ? offset + ADDR_W'(m2_q) : offset;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         m2_q   <= '0;
         m1_q   <= '0;
         rep_q  <= '0;
         k      <= '0;
         r      <= '0;
         p      <= '0;
         offset <= '0;
         dcnt   <= '0;
         en0    <= 1'b0;
         addr0  <= '0;
         last0  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !done) begin
                  m2_q   <= M2;
                  m1_q   <= M1dN1;
                  rep_q  <= rep;
                  k      <= '0;
                  r      <= '0;
                  p      <= '0;
                  offset <= '0;
                  busy   <= 1'b1;
                  if (M2 != '0 && M1dN1 != '0 && rep != '0) begin
                     state <= RUN;
                     en0   <= 1'b1;
                     addr0 <= '0;
                     last0 <= (M2 == ONE);
                  end else begin
                     // Empty job: skip the drain so done follows immediately
                     state <= DRAIN;
                     dcnt  <= DCNT_W'(DRAIN_LEN - 1);
                  end
               end
            end
            RUN: begin
               if (final_elem) begin
                  state <= DRAIN;
                  dcnt  <= '0;
                  en0   <= 1'b0;
                  addr0 <= '0;
                  last0 <= 1'b0;
               end else begin
                  k      <= k_nxt;
                  r      <= r_nxt;
                  p      <= p_adv ? p + ONE : p;
                  offset <= offset_nxt;
                  en0    <= 1'b1;
                  addr0  <= offset_nxt + ADDR_W'(k_nxt);
                  last0  <= (k_nxt == m2_q - ONE);
               end
            end
            DRAIN: begin
               if (dcnt == DCNT_W'(DRAIN_LEN - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  dcnt <= dcnt + DCNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [N1-1:0]     en_l, last_l;
   logic [ADDR_W-1:0] addr_l [N1];

   // Per-lane skew of the request, then read-latency alignment for valid/last
   for (genvar b = 0; b < N1; b++) begin : g_lane
      localparam int unsigned LSB = lane_lsb(b, ADDR_W);

      if (b == 0) begin : g_head
         assign en_l[b]   = en0;
         assign last_l[b] = last0;
         assign addr_l[b] = addr0;
      end else begin : g_skew
         skew_delay #(
            .DEPTH (b),
            .WIDTH (ADDR_W + 2)
         ) u_skew (
            .clk (clk),
            .rst (rst),
            .d   ({en0, last0, addr0}),
            .q   ({en_l[b], last_l[b], addr_l[b]})
         );
      end

      assign rd_en_A[b]               = en_l[b];
      assign rd_addr_A[LSB +: ADDR_W] = addr_l[b];

      if (RD_LAT == 0) begin : g_nolat
         assign lane_valid[b] = en_l[b];
         assign lane_last[b]  = last_l[b];
      end else begin : g_lat
         skew_delay #(
            .DEPTH (RD_LAT),
            .WIDTH (2)
         ) u_lat (
            .clk (clk),
            .rst (rst),
            .d   ({en_l[b], last_l[b]}),
            .q   ({lane_valid[b], lane_last[b]})
         );
      end
   end

endmodule

// File: tb/tb_mem_read_a.sv
// Bench for mem_read_a: two instances (12-bit and 4-bit addresses) driven in lockstep.
module tb_mem_read_a;

   localparam int unsigned N1     = 4;
   localparam int unsigned MW     = 16;
   localparam int unsigned AW     = 12;
   localparam int unsigned AW4    = 4;
   localparam int unsigned RD_LAT = 1;
   localparam int unsigned AWT    = N1 * AW;

   logic clk = 1'b0;
   logic rst, start;
   logic [MW-1:0] m2, m1dn1, rep;

   logic [N1-1:0]     en_a, valid_a, last_a, en_b, valid_b, last_b;
   logic [N1*AW-1:0]  addr_a;
   logic [N1*AW4-1:0] addr_b;
   logic              busy_a, done_a, busy_b, done_b;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_read_a #(.N1(N1), .MATRIXSIZE_W(MW), .ADDR_W(AW), .RD_LAT(RD_LAT)) u_dut (
      .clk(clk), .rst(rst), .start(start), .M2(m2), .M1dN1(m1dn1), .rep(rep),
      .rd_en_A(en_a), .rd_addr_A(addr_a), .lane_valid(valid_a), .lane_last(last_a),
      .busy(busy_a), .done(done_a)
   );

   mem_read_a #(.N1(N1), .MATRIXSIZE_W(MW), .ADDR_W(AW4), .RD_LAT(RD_LAT)) u_dut4 (
      .clk(clk), .rst(rst), .start(start), .M2(m2), .M1dN1(m1dn1), .rep(rep),
      .rd_en_A(en_b), .rd_addr_A(addr_b), .lane_valid(valid_b), .lane_last(last_b),
      .busy(busy_b), .done(done_b)
   );

   typedef struct {
      logic [N1-1:0]     en, valid, last;
      logic [N1*AW-1:0]  addr, mask;
      logic [N1*AW4-1:0] addr4, mask4;
      logic              busy, done;
   } exp_t;

   typedef struct {
      int m2, m1, rp, exp_done, repulse, rst_at;
   } vec_t;

   function automatic exp_t zero_exp(input bit full_mask);
      exp_t e;
      e.en = '0; e.valid = '0; e.last = '0;
      e.addr = '0; e.addr4 = '0;
      e.mask = full_mask ? '1 : '0;
      e.mask4 = full_mask ? '1 : '0;
      e.busy = 1'b0; e.done = 1'b0;
      return e;
   endfunction

   // Expected outputs c cycles after the start-sampling edge, straight from the timing rules
   function automatic exp_t model(input int c, input int m2v, input int m1v, input int rpv);
      exp_t e;
      int t, i, j, a;
      e = zero_exp(1'b0);
      t = m2v * m1v * rpv;
      if (t == 0) begin
         e.busy = (c == 1);
         e.done = (c == 2);
         return e;
      end
      e.busy = (c >= 1) && (c <= t + N1 + RD_LAT - 1);
      e.done = (c == t + N1 + RD_LAT);
      for (int b = 0; b < N1; b++) begin
         i = c - 1 - b;
         if (i >= 0 && i < t) begin
            a = ((i / m2v) / rpv) * m2v + (i % m2v);
            e.en[b] = 1'b1;
            e.addr[b*AW +: AW] = AW'(a);
            e.mask[b*AW +: AW] = '1;
            e.addr4[b*AW4 +: AW4] = AW4'(a);
            e.mask4[b*AW4 +: AW4] = '1;
         end
         j = i - RD_LAT;
         if (j >= 0 && j < t) begin
            e.valid[b] = 1'b1;
            e.last[b] = ((j % m2v) == m2v - 1);
         end
      end
      return e;
   endfunction

   task automatic check(input int c, input string tag, input logic [N1-1:0] en, valid, last,
                        input logic [N1*AW-1:0] addr, input logic busy, done,
                        input logic [N1-1:0] x_en, x_valid, x_last,
                        input logic [N1*AW-1:0] x_addr, mask, input logic x_busy, x_done);
      vectors++;
      if (en !== x_en || valid !== x_valid || last !== x_last || (addr & mask) !== x_addr ||
          busy !== x_busy || done !== x_done) begin
         miscompares++;
         $display("FAIL %s cyc%0d got/required: en=%h/%h valid=%h/%h last=%h/%h addr=%h/%h busy=%b/%b done=%b/%b",
                  tag, c, en, x_en, valid, x_valid, last, x_last, addr & mask, x_addr,
                  busy, x_busy, done, x_done);
      end
   endtask

   task automatic check_both(input int c, input string tag, input exp_t e);
      check(c, {tag, "/aw12"}, en_a, valid_a, last_a, addr_a, busy_a, done_a,
            e.en, e.valid, e.last, e.addr, e.mask, e.busy, e.done);
      check(c, {tag, "/aw4"}, en_b, valid_b, last_b, AWT'(addr_b), busy_b, done_b,
            e.en, e.valid, e.last, AWT'(e.addr4), AWT'(e.mask4), e.busy, e.done);
   endtask

   // Entered and left at posedge+1 with both DUTs idle
   task automatic run_vec(input int idx, input vec_t v);
      exp_t q[$];
      exp_t e;
      int last_c, first_done;
      string tag;
      tag = $sformatf("vec%0d", idx);
      last_c = (v.rst_at != 0) ? v.rst_at + 3 : v.exp_done + 2;
      m2 = MW'(v.m2); m1dn1 = MW'(v.m1); rep = MW'(v.rp);
      start = 1'b1;
      for (int c = 1; c <= last_c; c++) begin
         if (v.rst_at != 0 && c > v.rst_at) q.push_back(zero_exp(1'b1));
         else q.push_back(model(c, v.m2, v.m1, v.rp));
      end
      @(posedge clk); #1;
      start = 1'b0;
      first_done = 0;
      for (int c = 1; c <= last_c; c++) begin
         start = (v.repulse != 0 && c == v.repulse);
         if (start) begin
            m2 = MW'(7); m1dn1 = MW'(1); rep = MW'(3);
         end
         rst = (v.rst_at != 0 && c == v.rst_at);
         @(negedge clk);
         e = q.pop_front();
         check_both(c, tag, e);
         if (done_a && first_done == 0) first_done = c;
         @(posedge clk); #1;
      end
      start = 1'b0;
      rst = 1'b0;
      vectors++;
      if (first_done != v.exp_done || q.size() != 0) begin
         miscompares++;
         $display("FAIL %s done_cycle got %0d required %0d", tag, first_done, v.exp_done);
      end
   endtask

   vec_t vecs [10];

   initial begin
      vecs = '{
         '{3, 2, 1, 11, 0, 0},   // base scenario
         '{3, 2, 2, 17, 0, 0},   // each phase replayed twice
         '{3, 2, 0,  2, 0, 0},   // rep = 0
         '{0, 2, 1,  2, 0, 0},   // M2 = 0
         '{3, 0, 1,  2, 0, 0},   // M1dN1 = 0
         '{3, 2, 1, 11, 4, 0},   // start re-pulsed mid-run
         '{3, 2, 1,  0, 0, 5},   // reset mid-run
         '{3, 2, 1, 11, 0, 0},   // fresh start after reset
         '{5, 4, 1, 25, 0, 0},   // 4-bit instance wraps its offset
         '{1, 1, 1,  6, 0, 0}    // single-element job
      };
      rst = 1'b1; start = 1'b0;
      m2 = '0; m1dn1 = '0; rep = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_both(0, "reset", zero_exp(1'b1));
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         run_vec(i, vecs[i]);
         repeat (2) @(posedge clk);
         #1;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
